cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_if.sv | 25 ++
 rtl/cacheline_adapter.sv | 85 ++++++++
 tb/tb_cacheline_adapter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// rtl/cacheline_adapter_if.sv - upstream line port and memory burst port of the cacheline adapter
interface cacheline_adapter_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - converts 256-bit line reads/writes into four 64-bit memory beats
module cacheline_adapter (
  input  logic               clk,
  input  logic               rst,
  cacheline_adapter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wline_q, wline_d;
  logic [255:0]   rline_q, rline_d;
  logic [31:0]    aligned_addr;

  assign aligned_addr = bus.address_i & 32'hFFFF_FFE0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= 256'd0;
      rline_q <= 256'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Read wins over write when both are requested in the same IDLE cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          addr_d  = aligned_addr;
          k_d     = 2'd0;
          state_d = READ;
        end else if (bus.write_i) begin
          addr_d  = aligned_addr;
          wline_d = bus.line_i;
          k_d     = 2'd0;
          state_d = WRITE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_d[{k_q, 6'd0} +: 64] = bus.burst_i;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_o    = (state_q == READ);
  assign bus.write_o   = (state_q == WRITE);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = rline_q;
  assign bus.burst_o   = (state_q == WRITE) ? wline_q[{k_q, 6'd0} +: 64] : 64'd0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed table-driven bench for cacheline_adapter
module tb_cacheline_adapter;

  logic clk;
  logic rst;
  cacheline_adapter_if bus ();

  cacheline_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              exp_rd;
    logic              exp_wr;
    logic [31:0]       addr;
    logic [31:0]       exp_addr;
    logic [255:0]      wline;
    logic [3:0][63:0]  beats;
    logic [3:0][63:0]  exp_burst;
    logic [7:0]        pat;
    logic [3:0]        pat_len;
    logic [3:0]        req_cycles;
    logic [255:0]      exp_line;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [7];

  function automatic vec_t mk(input logic rd, input logic wr, input logic erd, input logic ewr,
                              input logic [31:0] addr, input logic [31:0] eaddr,
                              input logic [255:0] wline, input logic [255:0] beats,
                              input logic [255:0] eburst, input logic [7:0] pat,
                              input logic [3:0] plen, input logic [3:0] req,
                              input logic [255:0] eline);
    vec_t v;
    v.rd = rd; v.wr = wr; v.exp_rd = erd; v.exp_wr = ewr;
    v.addr = addr; v.exp_addr = eaddr; v.wline = wline;
    v.beats = beats; v.exp_burst = eburst; v.pat = pat;
    v.pat_len = plen; v.req_cycles = req; v.exp_line = eline;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int  nb;
    bit  done;
    logic r;
    nb   = 0;
    done = 1'b0;
    bus.read_i    = v.rd;
    bus.write_i   = v.wr;
    bus.address_i = v.addr;
    bus.line_i    = v.wline;
    bus.resp_i    = 1'b0;
    bus.burst_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc >= int'(v.req_cycles)) begin
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
      end
      if (nb < 4) begin
        chk({tag, " read_o"},    bus.read_o,    v.exp_rd);
        chk({tag, " write_o"},   bus.write_o,   v.exp_wr);
        chk({tag, " resp_o"},    bus.resp_o,    1'b0);
        chk({tag, " address_o"}, bus.address_o, v.exp_addr);
        chk({tag, " burst_o"},   bus.burst_o,   v.exp_wr ? v.exp_burst[nb] : 64'd0);
        r = (cyc - 1 < int'(v.pat_len)) ? v.pat[cyc - 1] : 1'b1;
        bus.resp_i  = r;
        bus.burst_i = r ? v.beats[nb] : 64'hDEAD_BEEF_DEAD_BEEF;
        if (r) nb++;
      end else begin
        chk({tag, " done resp_o"},    bus.resp_o,    1'b1);
        chk({tag, " done read_o"},    bus.read_o,    1'b0);
        chk({tag, " done write_o"},   bus.write_o,   1'b0);
        chk({tag, " done line_o"},    bus.line_o,    v.exp_line);
        chk({tag, " done address_o"}, bus.address_o, v.exp_addr);
        bus.resp_i = 1'b1;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({tag, " completed"}, done, 1'b1);
    chk({tag, " idle resp_o"},  bus.resp_o,  1'b0);
    chk({tag, " idle read_o"},  bus.read_o,  1'b0);
    chk({tag, " idle write_o"}, bus.write_o, 1'b0);
    chk({tag, " idle burst_o"}, bus.burst_o, 64'd0);
    chk({tag, " idle line_o"},  bus.line_o,  v.exp_line);
    bus.resp_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " still idle"}, {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
  endtask

  initial begin
    vecs[0] = mk(1, 0, 1, 0, 32'h1234_5678, 32'h1234_5660, 256'd0,
                 {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 256'd0, 8'b0000_1111, 4'd4, 4'd1,
                 {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    vecs[1] = mk(1, 0, 1, 0, 32'h0000_0ABC, 32'h0000_0AA0, 256'd0,
                 {64'hDDDD_EEEE_FFFF_0000, 64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444},
                 256'd0, 8'b0101_1001, 4'd7, 4'd1,
                 {64'hDDDD_EEEE_FFFF_0000, 64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
    vecs[2] = mk(0, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                 {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001},
                 256'd0,
                 {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001},
                 8'b0000_1111, 4'd4, 4'd1,
                 {64'hDDDD_EEEE_FFFF_0000, 64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
    vecs[3] = mk(1, 1, 1, 0, 32'h8000_0020, 32'h8000_0020, {4{64'hBAD0_BAD0_BAD0_BAD0}},
                 {64'hDD00_0000_0000_0003, 64'hDD00_0000_0000_0002, 64'hDD00_0000_0000_0001, 64'hDD00_0000_0000_0000},
                 256'd0, 8'b0001_1011, 4'd5, 4'd1,
                 {64'hDD00_0000_0000_0003, 64'hDD00_0000_0000_0002, 64'hDD00_0000_0000_0001, 64'hDD00_0000_0000_0000});
    vecs[4] = mk(0, 1, 0, 1, 32'h0000_0040, 32'h0000_0040,
                 {64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                 256'd0,
                 {64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                 8'b0110_0110, 4'd7, 4'd1,
                 {64'hDD00_0000_0000_0003, 64'hDD00_0000_0000_0002, 64'hDD00_0000_0000_0001, 64'hDD00_0000_0000_0000});
    vecs[5] = mk(1, 0, 1, 0, 32'h0000_003F, 32'h0000_0020, 256'd0,
                 {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 256'd0, 8'b0000_1111, 4'd4, 4'd2,
                 {64'hE3, 64'hE2, 64'hE1, 64'hE0});
    vecs[6] = mk(1, 0, 1, 0, 32'h7654_321F, 32'h7654_3200, 256'd0,
                 {64'h6000_0000_0000_0003, 64'h6000_0000_0000_0002, 64'h6000_0000_0000_0001, 64'h6000_0000_0000_0000},
                 256'd0, 8'b0000_1111, 4'd4, 4'd1,
                 {64'h6000_0000_0000_0003, 64'h6000_0000_0000_0002, 64'h6000_0000_0000_0001, 64'h6000_0000_0000_0000});

    rst = 1'b1;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset read_o",    bus.read_o,    1'b0);
    chk("reset write_o",   bus.write_o,   1'b0);
    chk("reset resp_o",    bus.resp_o,    1'b0);
    chk("reset address_o", bus.address_o, 32'd0);
    chk("reset burst_o",   bus.burst_o,   64'd0);
    chk("reset line_o",    bus.line_o,    256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort a read after its second beat with a reset.
    bus.read_i = 1'b1; bus.write_i = 1'b0; bus.address_i = 32'h0000_0100; bus.resp_i = 1'b0;
    @(posedge clk); #1;
    bus.read_i = 1'b0;
    bus.resp_i = 1'b1; bus.burst_i = 64'hF0;
    @(posedge clk); #1;
    bus.burst_i = 64'hF1;
    @(posedge clk); #1;
    chk("abort read_o before rst", bus.read_o, 1'b1);
    rst = 1'b1; bus.burst_i = 64'hF2;
    @(posedge clk); #1;
    chk("abort read_o",    bus.read_o,    1'b0);
    chk("abort line_o",    bus.line_o,    256'd0);
    chk("abort resp_o",    bus.resp_o,    1'b0);
    chk("abort address_o", bus.address_o, 32'd0);
    chk("abort burst_o",   bus.burst_o,   64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post-abort quiet", {bus.read_o, bus.resp_o, bus.line_o}, 258'd0);
    end
    bus.resp_i = 1'b0;
    run_txn(vecs[6], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
